spi_master_param: RTL
=====================

Name: spi_master_param

Overview:
Parametrised, second-generation SPI master: configurable frame width, chip-select count, runtime clock divider, all four SPI modes, MSB/LSB-first ordering, and multi-frame bursts with chip-select held. Sits between a local controller (start/done handshake) and external SPI slaves. Drives one of NUM_SS active-low selects per transfer.

Parameters:
DATA_W, 8, frame width in bits (2..32)
NUM_SS, 4, number of chip-select outputs (1..16)
CLKDIV_W, 8, width of clkdiv input; SCLK half-period = clkdiv+1 clk cycles

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  request a frame; accepted only when busy=0
mode  in  2  SPI mode; CPOL=mode[1], CPHA=mode[0]
clkdiv  in  CLKDIV_W  half-period minus one, in clk cycles
lsb_first  in  1  1: shift/receive LSB first; 0: MSB first
hold  in  1  level: keep SS asserted after frame (burst)
ss_sel  in  clog2(NUM_SS) (min 1)  target slave index
tx_data  in  DATA_W  word to transmit
rx_data  out  DATA_W  last received word, valid with done
busy  out  1  high from the cycle after acceptance until done
done  out  1  one-cycle pulse at frame end
MISO  in  1  serial data from slave
MOSI  out  1  serial data to slave
Sclk  out  1  serial clock
SS  out  NUM_SS  active-low chip selects

Behaviour:
- Reset (rst=0, async): state IDLE, SS all 1, Sclk=0, MOSI=0, rx_data=0, busy=0, done=0, counters cleared; takes effect mid-frame immediately, no partial done.
- States: IDLE, SETUP, LEAD, TRAIL, HOLD. Every timed state lasts H = clkdiv+1 clk cycles (half-period counter).
- IDLE: Sclk registered to current mode[1] each cycle; SS all 1. start=1 -> latch mode, clkdiv, lsb_first, tx_data, ss_sel, hold; next cycle SETUP, busy=1, SS[ss_sel]=0.
- ss_sel >= NUM_SS: frame still runs, SS stays all 1.
- SETUP: Sclk=CPOL. CPHA=0: first bit on MOSI at SETUP entry. -> LEAD after H.
- LEAD: Sclk=~CPOL. CPHA=0: sample MISO at entry. CPHA=1: drive next bit at entry. -> TRAIL after H.
- TRAIL: Sclk=CPOL. CPHA=0: drive next bit at entry (except after last bit). CPHA=1: sample MISO at entry. Bit counter increments at TRAIL exit; after DATA_W pairs -> frame end, else LEAD.
- Bit order: lsb_first=0 sends tx_data[DATA_W-1] first; received bits fill so rx_data matches the slave's word in the same order.
- Frame end: rx_data updated and done=1 in the same cycle; busy=0 that cycle. Latched hold=1 -> HOLD; else IDLE, SS all 1 that cycle.
- Total SS-low time per single frame = (2*DATA_W+1)*H cycles.
- HOLD: SS kept, Sclk=CPOL, busy=0. start=1 -> relatch tx_data, lsb_first, hold (mode, clkdiv, ss_sel keep burst values), -> SETUP. start=0 and hold=0 -> IDLE, SS deasserted next cycle. start=1 wins if both conditions hold.
- start while busy=1: ignored, no queueing. Input changes mid-frame: no effect.
- clkdiv=0: H=1, SCLK = clk/2, must work.

Optional Feature:
SPI_LOOPBACK_EN: when defined, adds input port loopback (1 bit); loopback=1 routes internal MOSI to the sampling path instead of MISO (MOSI pin still driven), so rx_data==tx_data. When undefined, the port is absent and MISO is always sampled.

Test Plan:
- DATA_W=8, mode 0, clkdiv=1, tx 0xA5, slave model returns 0x3C MSB first -> MOSI 1,0,1,0,0,1,0,1; 8 Sclk rising edges 4 clk apart; SS low 34 cycles; rx_data=0x3C, one done pulse.
- Mode 3, lsb_first=1, clkdiv=0, tx 0x81, slave 0xF0 LSB first -> Sclk idles 1, MOSI 1,0,0,0,0,0,0,1; rx_data=0xF0.
- Burst: hold=1, tx 0x11 then start in HOLD with 0x22 and hold=0 -> SS[2] low continuously across both frames; two done pulses; SS high the cycle of the second done.
- start pulsed mid-frame with different tx_data -> ignored; single frame completes unchanged; busy never drops early.
- rst asserted at bit 4 of a mode-1 frame -> SS all 1, Sclk=0, busy=0, done=0 immediately; next start yields a clean full frame.
- SPI_LOOPBACK_EN, loopback=1, tx 0x5A, MISO tied 0 -> rx_data=0x5A.

Source files
------------

// File: rtl/spi_master_param_if.sv
// Controller- and pin-side signal bundle for spi_master_param.
// Optional: SPI_LOOPBACK_EN adds the loopback control input.
interface spi_master_param_if #(
    parameter int DATA_W   = 8,
    parameter int NUM_SS   = 4,
    parameter int CLKDIV_W = 8
);
    localparam int SS_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;

    logic                start;
    logic [1:0]          mode;
    logic [CLKDIV_W-1:0] clkdiv;
    logic                lsb_first;
    logic                hold;
    logic [SS_W-1:0]     ss_sel;
    logic [DATA_W-1:0]   tx_data;
    logic [DATA_W-1:0]   rx_data;
    logic                busy;
    logic                done;
    logic                MISO;
    logic                MOSI;
    logic                Sclk;
    logic [NUM_SS-1:0]   SS;
`ifdef SPI_LOOPBACK_EN
    logic                loopback;
`endif

    modport master (
        input  start, mode, clkdiv, lsb_first, hold, ss_sel, tx_data, MISO,
`ifdef SPI_LOOPBACK_EN
        input  loopback,
`endif
        output rx_data, busy, done, MOSI, Sclk, SS
    );

    modport slave (
        output start, mode, clkdiv, lsb_first, hold, ss_sel, tx_data, MISO,
`ifdef SPI_LOOPBACK_EN
        output loopback,
`endif
        input  rx_data, busy, done, MOSI, Sclk, SS
    );
endinterface

// File: rtl/spi_master_param.sv
// Parametrised SPI master: runtime divider, 4 modes, MSB/LSB order,
// chip-select held across frames via the HOLD state.
// Optional: `define SPI_LOOPBACK_EN routes MOSI back into the sample path.
module spi_master_param #(
    parameter int DATA_W   = 8,
    parameter int NUM_SS   = 4,
    parameter int CLKDIV_W = 8
) (
    input  logic clk,
    input  logic rst,
    spi_master_param_if.master bus
);
    localparam int SS_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
    localparam int BC_W = $clog2(DATA_W);

    typedef enum logic [2:0] {IDLE, SETUP, LEAD, TRAIL, HOLD} state_t;

    state_t              state_q;
    logic [CLKDIV_W-1:0] cnt_q, clkdiv_q;
    logic [BC_W-1:0]     bit_q;
    logic [1:0]          mode_q;
    logic                lsb_q, hold_q;
    logic [DATA_W-1:0]   tx_q, rx_sh_q, rx_q;
    logic                sclk_q, mosi_q, busy_q, done_q;
    logic [NUM_SS-1:0]   ss_q;

    logic                hp_end, last_bit, samp_d;
    logic [NUM_SS-1:0]   ss_dec_d;

    // Bit k of a word in transmit order.
    function automatic logic pick(input logic [DATA_W-1:0] w, input logic lsb,
                                  input logic [BC_W-1:0] k);
        logic [BC_W-1:0] idx;
        idx = lsb ? k : (BC_W'(DATA_W - 1) - k);
        return w[idx];
    endfunction

    // Shift a received bit in so the final word lines up with the slave's order.
    function automatic logic [DATA_W-1:0] shin(input logic [DATA_W-1:0] sh,
                                               input logic lsb, input logic b);
        return lsb ? {b, sh[DATA_W-1:1]} : {sh[DATA_W-2:0], b};
    endfunction

    // Half-period end, last-bit flag, sample source and select decode.
    always_comb begin
        hp_end   = (cnt_q == clkdiv_q);
        last_bit = (bit_q == BC_W'(DATA_W - 1));
`ifdef SPI_LOOPBACK_EN
        samp_d   = bus.loopback ? mosi_q : bus.MISO;
`else
        samp_d   = bus.MISO;
`endif
        // Out-of-range index matches nothing, so all selects stay high.
        ss_dec_d = '1;
        for (int i = 0; i < NUM_SS; i++)
            if (bus.ss_sel == SS_W'(i)) ss_dec_d[i] = 1'b0;
    end

    // Frame sequencer with all pin and handshake outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            clkdiv_q <= '0;
            bit_q    <= '0;
            mode_q   <= '0;
            lsb_q    <= 1'b0;
            hold_q   <= 1'b0;
            tx_q     <= '0;
            rx_sh_q  <= '0;
            rx_q     <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ss_q     <= '1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    sclk_q <= bus.mode[1];
                    ss_q   <= '1;
                    if (bus.start) begin
                        mode_q   <= bus.mode;
                        clkdiv_q <= bus.clkdiv;
                        lsb_q    <= bus.lsb_first;
                        hold_q   <= bus.hold;
                        tx_q     <= bus.tx_data;
                        ss_q     <= ss_dec_d;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        bit_q    <= '0;
                        rx_sh_q  <= '0;
                        if (!bus.mode[0]) mosi_q <= pick(bus.tx_data, bus.lsb_first, '0);
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    if (hp_end) begin
                        cnt_q   <= '0;
                        sclk_q  <= ~mode_q[1];
                        state_q <= LEAD;
                        if (!mode_q[0]) rx_sh_q <= shin(rx_sh_q, lsb_q, samp_d);
                        else            mosi_q  <= pick(tx_q, lsb_q, bit_q);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                LEAD: begin
                    if (hp_end) begin
                        cnt_q   <= '0;
                        sclk_q  <= mode_q[1];
                        state_q <= TRAIL;
                        if (!mode_q[0]) begin
                            if (!last_bit) mosi_q <= pick(tx_q, lsb_q, bit_q + 1'b1);
                        end else begin
                            rx_sh_q <= shin(rx_sh_q, lsb_q, samp_d);
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                TRAIL: begin
                    if (hp_end) begin
                        cnt_q <= '0;
                        if (last_bit) begin
                            rx_q   <= rx_sh_q;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            bit_q  <= '0;
                            if (hold_q) begin
                                state_q <= HOLD;
                            end else begin
                                state_q <= IDLE;
                                ss_q    <= '1;
                            end
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            sclk_q  <= ~mode_q[1];
                            state_q <= LEAD;
                            if (!mode_q[0]) rx_sh_q <= shin(rx_sh_q, lsb_q, samp_d);
                            else            mosi_q  <= pick(tx_q, lsb_q, bit_q + 1'b1);
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    sclk_q <= mode_q[1];
                    // A new start takes priority over releasing the burst.
                    if (bus.start) begin
                        lsb_q   <= bus.lsb_first;
                        hold_q  <= bus.hold;
                        tx_q    <= bus.tx_data;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        rx_sh_q <= '0;
                        if (!mode_q[0]) mosi_q <= pick(bus.tx_data, bus.lsb_first, '0);
                        state_q <= SETUP;
                    end else if (!bus.hold) begin
                        ss_q    <= '1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rx_data = rx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.MOSI    = mosi_q;
    assign bus.Sclk    = sclk_q;
    assign bus.SS      = ss_q;
endmodule
